load_align_queue: RTL

- Pipelined load-return unit between the LSU request stage and register writeback.
- Tracks up to DEPTH outstanding loads in order and issues memory requests for aligned ones.
- Aligns and sign/zero-extends returned words, merges LWL/LWR with the old rt value, and produces per-byte write enables.
- Detects misaligned LH/LHU/LW, supports pipeline flush, and holds results in a valid/ready output register.

---
 rtl/load_pkg.sv | 47 ++++
 rtl/load_align_queue_fmt.sv | 49 ++++
 rtl/load_align_queue.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/load_pkg.sv
// Shared load-return definitions: select encodings, queue entry layout and lane helpers.
package load_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    SEL_LB  = 3'd0,
    SEL_LH  = 3'd1,
    SEL_LWL = 3'd2,
    SEL_LW  = 3'd3,
    SEL_LBU = 3'd4,
    SEL_LHU = 3'd5,
    SEL_LWR = 3'd6,
    SEL_ILL = 3'd7
  } load_sel_e;

  typedef struct packed {
    logic [1:0]        addr;
    load_sel_e         sel;
    logic [DATA_W-1:0] rt;
    logic              exc;
  } load_entry_t;

  // Big-endian lanes: byte offset 0 lives in bits [31:24].
  function automatic logic [7:0] lane_byte(logic [DATA_W-1:0] w, logic [1:0] a);
    logic [DATA_W-1:0] t;
    t = w >> {2'd3 - a, 3'b000};
    return t[7:0];
  endfunction

  function automatic logic [15:0] lane_half(logic [DATA_W-1:0] w, logic hi_off);
    return hi_off ? w[15:0] : w[31:16];
  endfunction

  function automatic logic [3:0] lwl_mask(logic [1:0] a);
    logic [3:0] m;
    m = 4'b1111 << a;
    return m;
  endfunction

  function automatic logic [3:0] lwr_mask(logic [1:0] a);
    logic [3:0] m;
    m = 4'b1111 >> (2'd3 - a);
    return m;
  endfunction

endpackage

// File: rtl/load_align_queue_fmt.sv
// Combinational load formatter: lane extraction, extension and LWL/LWR merge with byte enables.
module load_fmt
  import load_pkg::*;
(
  input  logic [2:0]        sel,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] w,
  input  logic [DATA_W-1:0] rt,
  output logic [DATA_W-1:0] data,
  output logic [3:0]        en
);

  load_sel_e         sel_e;
  logic [7:0]        b;
  logic [15:0]       h;
  logic [DATA_W-1:0] shifted;

  always_comb begin
    sel_e   = load_sel_e'(sel);
    b       = lane_byte(w, addr);
    h       = lane_half(w, addr[1]);
    data    = '0;
    en      = '1;
    shifted = '0;
    case (sel_e)
      SEL_LB:  data = {{24{b[7]}}, b};
      SEL_LBU: data = {24'h0, b};
      SEL_LH:  data = {{16{h[15]}}, h};
      SEL_LHU: data = {16'h0, h};
      SEL_LW:  data = w;
      SEL_LWL: begin
        en      = lwl_mask(addr);
        shifted = w << {addr, 3'b000};
      end
      SEL_LWR: begin
        en      = lwr_mask(addr);
        shifted = w >> {2'd3 - addr, 3'b000};
      end
      default: en = '0;
    endcase
    // Partial-word loads keep the old rt value in the disabled byte lanes.
    if (sel_e == SEL_LWL || sel_e == SEL_LWR) begin
      for (int unsigned i = 0; i < 4; i++) begin
        data[8*i +: 8] = en[i] ? shifted[8*i +: 8] : rt[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/load_align_queue.sv
// In-order load-return queue: issues aligned loads, formats returned data, buffers one result.
module load_align_queue
  import load_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DEST_W = 5,
  parameter bit          EXC_EN = 1'b1
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_addr,
  input  logic [2:0]        req_sel,
  input  logic [31:0]       req_rt,
  input  logic [DEST_W-1:0] req_dest,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  input  logic              mem_rsp_valid,
  output logic              mem_rsp_ready,
  input  logic [31:0]       mem_rsp_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [3:0]        out_byte_en,
  output logic [DEST_W-1:0] out_dest,
  output logic              out_exc
);

  localparam int unsigned AW = $clog2(DEPTH);

  load_sel_e   req_sel_e;
  logic        mis_raw;
  logic        mis;
  logic [1:0]  addr_eff;

  always_comb begin
    req_sel_e = load_sel_e'(req_sel);
    mis_raw   = 1'b0;
    addr_eff  = req_addr;
    case (req_sel_e)
      SEL_LH, SEL_LHU: begin
        mis_raw = req_addr[0];
        if (!EXC_EN) addr_eff = {req_addr[1], 1'b0};
      end
      SEL_LW: begin
        mis_raw = (req_addr != 2'd0);
        if (!EXC_EN) addr_eff = 2'd0;
      end
      SEL_ILL: mis_raw = 1'b1;
      default: ;
    endcase
    mis = EXC_EN ? mis_raw : (req_sel_e == SEL_ILL);
  end

  load_entry_t       ent_q  [DEPTH];
  logic [DEST_W-1:0] dest_q [DEPTH];
  logic [DEPTH-1:0]  kill_q;
  logic [AW:0]       wr_ptr_q, rd_ptr_q;
  logic [AW-1:0]     wr_idx, rd_idx;
  logic              full, empty, push, pop, kill_eff, load_out, out_free;
  load_entry_t       head;

  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_data_q, out_data_d;
  logic [3:0]        out_en_q, out_en_d;
  logic [DEST_W-1:0] out_dest_q, out_dest_d;
  logic              out_exc_q, out_exc_d;
  logic [31:0]       fmt_data;
  logic [3:0]        fmt_en;

  assign wr_idx   = wr_ptr_q[AW-1:0];
  assign rd_idx   = rd_ptr_q[AW-1:0];
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign head     = ent_q[rd_idx];
  assign kill_eff = kill_q[rd_idx] || flush;
  assign out_free = !out_valid_q || out_ready;

  assign req_ready     = !full && !flush && (mis || mem_req_ready);
  assign mem_req_valid = req_valid && !full && !flush && !mis;
  assign push          = req_valid && req_ready;
  assign mem_rsp_ready = !empty && !head.exc && out_free;

  // Exception heads resolve without memory data; killed heads pop but never load the output.
  assign pop      = !empty && (head.exc ? out_free : (mem_rsp_valid && mem_rsp_ready));
  assign load_out = pop && !kill_eff;

  load_fmt u_fmt (
    .sel  (head.sel),
    .addr (head.addr),
    .w    (mem_rsp_data),
    .rt   (head.rt),
    .data (fmt_data),
    .en   (fmt_en)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      kill_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_q[i]  <= '0;
        dest_q[i] <= '0;
      end
    end else begin
      if (flush) kill_q <= '1;
      if (push) begin
        ent_q[wr_idx]  <= '{addr: addr_eff, sel: req_sel_e, rt: req_rt, exc: mis};
        dest_q[wr_idx] <= req_dest;
        kill_q[wr_idx] <= 1'b0;
        wr_ptr_q       <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_en_d    = out_en_q;
    out_dest_d  = out_dest_q;
    out_exc_d   = out_exc_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (load_out) begin
      out_valid_d = 1'b1;
      out_data_d  = head.exc ? '0 : fmt_data;
      out_en_d    = head.exc ? '0 : fmt_en;
      out_dest_d  = dest_q[rd_idx];
      out_exc_d   = head.exc;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_en_q    <= '0;
      out_dest_q  <= '0;
      out_exc_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_en_q    <= out_en_d;
      out_dest_q  <= out_dest_d;
      out_exc_q   <= out_exc_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_byte_en = out_en_q;
  assign out_dest    = out_dest_q;
  assign out_exc     = out_exc_q;

endmodule
